// File: rtl/ebs_regfile_sampler.sv
// ebs_regfile_sampler
// Requester side of the EBS register-file snapshot port. On an enabled sample
// event it presents four register indices to the issue stage, captures the
// returned values one cycle later, tags them with the event PC and buffers the
// record in a small FIFO drained through a valid/ready stream.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i, sample_req_i      sampler enable, single-cycle sample event
//   sample_pc_i             PC tag captured with the event
//   sample_regs_i           4 x 5-bit register indices captured with the event
//   ebs_regfile_addr_o      indices presented to the issue stage (0 when idle)
//   ebs_regfile_data_i      4 x XLEN values, valid one cycle after the address
//   rec_valid_o/rec_ready_i head-of-FIFO stream handshake
//   rec_pc_o, rec_data_o    head record (zero when the FIFO is empty)
//   busy_o                  capture in flight
//   drop_cnt_o              saturating count of lost samples
module ebs_regfile_sampler #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned VLEN       = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       sample_req_i,
    input  logic [VLEN-1:0]            sample_pc_i,
    input  logic [3:0][4:0]            sample_regs_i,
    output logic [3:0][4:0]            ebs_regfile_addr_o,
    input  logic [3:0][XLEN-1:0]       ebs_regfile_data_i,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic [VLEN-1:0]            rec_pc_o,
    output logic [3:0][XLEN-1:0]       rec_data_o,
    output logic                       busy_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = DROP_CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CAPT = 2'd2
    } state_e;

    typedef struct packed {
        logic [VLEN-1:0]      pc;
        logic [3:0][XLEN-1:0] data;
    } rec_t;

    state_e                 state_q, state_d;
    logic [3:0][4:0]        addr_q, addr_d;
    logic [VLEN-1:0]        pc_q, pc_d;
    logic                   busy_q, busy_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    rec_t                   mem_q [FIFO_DEPTH];

    logic                   req;
    logic                   push;
    logic                   push_ok;
    logic                   pop;
    logic                   full;
    logic                   rec_valid;
    logic                   req_drop;
    logic                   fifo_drop;
    logic [1:0]             drop_inc;
    logic [SUM_W-1:0]       drop_sum;
    rec_t                   rec_wr;
    rec_t                   rec_head;

    // Next-state, FIFO bookkeeping and drop accounting
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        busy_d    = busy_q;
        push      = 1'b0;
        req_drop  = 1'b0;
        req       = en_i & sample_req_i;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ADDR;
                    addr_d  = sample_regs_i;
                    pc_d    = sample_pc_i;
                    busy_d  = 1'b1;
                end
            end
            ADDR: begin
                state_d  = CAPT;
                req_drop = req;
            end
            CAPT: begin
                state_d  = IDLE;
                addr_d   = '0;
                busy_d   = 1'b0;
                push     = 1'b1;
                req_drop = req;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                busy_d  = 1'b0;
            end
        endcase

        rec_valid = (count_q != '0);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        pop       = rec_valid & rec_ready_i;
        // A full FIFO still accepts the record when its head leaves this cycle
        push_ok   = push & (~full | pop);
        fifo_drop = push & ~push_ok;

        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        // Up to two drops per cycle; the extra MSB detects saturation
        drop_inc   = 2'(req_drop) + 2'(fifo_drop);
        drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(drop_inc);
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

        rec_wr.pc   = pc_q;
        rec_wr.data = ebs_regfile_data_i;
    end

    // State and control registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pc_q       <= '0;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record storage; contents need no reset because empty reads are masked
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= rec_wr;
        end
    end

    assign rec_head           = mem_q[rd_ptr_q];
    assign rec_valid_o        = rec_valid;
    assign rec_pc_o           = rec_valid ? rec_head.pc : '0;
    assign rec_data_o         = rec_valid ? rec_head.data : '0;
    assign ebs_regfile_addr_o = addr_q;
    assign busy_o             = busy_q;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_ebs_regfile_sampler.sv
// tb_ebs_regfile_sampler
// Bench for ebs_regfile_sampler: directed scenarios followed by random traffic.
// A queue of expected records is filled when captures complete in the reference
// model; an independent monitor pops and compares whenever the DUT hands a
// record over. A second instance with a 2-bit drop counter shares the stimulus.
module tb_ebs_regfile_sampler;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned VLEN  = 64;
    localparam int unsigned DEPTH = 4;

    typedef logic [3:0][4:0] regs_t;
    typedef struct {
        logic [VLEN-1:0]      pc;
        logic [3:0][XLEN-1:0] data;
    } rec_t;

    logic                  clk;
    logic                  rst_i;
    logic                  en_i;
    logic                  sample_req_i;
    logic [VLEN-1:0]       sample_pc_i;
    regs_t                 sample_regs_i;
    regs_t                 addr_o;
    logic [3:0][XLEN-1:0]  data_i;
    logic                  rec_valid_o;
    logic                  rec_ready_i;
    logic [VLEN-1:0]       rec_pc_o;
    logic [3:0][XLEN-1:0]  rec_data_o;
    logic                  busy_o;
    logic [15:0]           drop_cnt_o;

    regs_t                 s_addr;
    logic                  s_valid;
    logic [VLEN-1:0]       s_pc;
    logic [3:0][XLEN-1:0]  s_data;
    logic                  s_busy;
    logic [1:0]            s_drop;

    ebs_regfile_sampler #(
        .XLEN(XLEN), .VLEN(VLEN), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sample_req_i(sample_req_i),
        .sample_pc_i(sample_pc_i), .sample_regs_i(sample_regs_i),
        .ebs_regfile_addr_o(addr_o), .ebs_regfile_data_i(data_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_pc_o(rec_pc_o), .rec_data_o(rec_data_o),
        .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    ebs_regfile_sampler #(
        .XLEN(XLEN), .VLEN(VLEN), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(2)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .sample_req_i(sample_req_i),
        .sample_pc_i(sample_pc_i), .sample_regs_i(sample_regs_i),
        .ebs_regfile_addr_o(s_addr), .ebs_regfile_data_i(data_i),
        .rec_valid_o(s_valid), .rec_ready_i(rec_ready_i),
        .rec_pc_o(s_pc), .rec_data_o(s_data),
        .busy_o(s_busy), .drop_cnt_o(s_drop)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Issue-stage register file model: answers one cycle after the address
    logic [XLEN-1:0] rf [32];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) data_i[k] <= rf[addr_o[k]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    rec_t  exp_q [$];
    int    m_busy_left;
    regs_t m_regs;
    rec_t  m_pend;
    int    m_occ;
    int    m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic regs_t mk_regs(input int a, input int b, input int c, input int d);
        regs_t r;
        r[0] = 5'(a); r[1] = 5'(b); r[2] = 5'(c); r[3] = 5'(d);
        return r;
    endfunction

    // One clock: drive inputs, advance the model through the edge, check outputs
    task automatic step(input logic en, input logic req, input logic [63:0] pc,
                        input regs_t regs, input logic rdy, input logic rst);
        logic pop;
        rst_i = rst; en_i = en; sample_req_i = req;
        sample_pc_i = pc; sample_regs_i = regs; rec_ready_i = rdy;

        if (rst) begin
            m_busy_left = 0; m_occ = 0; m_drop = 0; m_regs = '0;
            exp_q.delete();
        end else begin
            pop = (m_occ > 0) && rdy;
            if (en && req && m_busy_left != 0) m_drop++;
            if (m_busy_left == 1) begin
                for (int k = 0; k < 4; k++) m_pend.data[k] = rf[m_regs[k]];
                if (m_occ < int'(DEPTH) || pop) begin
                    exp_q.push_back(m_pend);
                    m_occ++;
                end else begin
                    m_drop++;
                end
            end
            if (pop) m_occ--;
            if (m_drop > 65535) m_drop = 65535;
            if (m_busy_left != 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_regs = '0;
            end else if (en && req) begin
                m_busy_left = 2;
                m_regs      = regs;
                m_pend.pc   = pc;
            end
        end

        @(posedge clk);
        #1;
        chk("busy", 64'(busy_o), 64'(m_busy_left != 0));
        chk("addr", 64'(addr_o), 64'(m_regs));
        chk("valid", 64'(rec_valid_o), 64'(m_occ != 0));
        chk("drop", 64'(drop_cnt_o), 64'(m_drop));
        chk("drop_sat", 64'(s_drop), 64'((m_drop > 3) ? 3 : m_drop));
        if (m_occ == 0) chk("pc_empty", rec_pc_o, 64'd0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'd0, '0, rdy, 1'b0);
    endtask

    task automatic req1(input logic [63:0] pc, input regs_t regs, input logic rdy);
        step(1'b1, 1'b1, pc, regs, rdy, 1'b0);
    endtask

    // Monitor: compares each handed-over record against the scoreboard
    rec_t mon_r;
    always @(negedge clk) begin
        if (rec_valid_o === 1'b1 && rec_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_record: got pc %0h expected none at %0t", rec_pc_o, $time);
            end else begin
                mon_r = exp_q.pop_front();
                chk("rec_pc", rec_pc_o, mon_r.pc);
                for (int k = 0; k < 4; k++) chk("rec_data", rec_data_o[k], mon_r.data[k]);
            end
        end
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b0; sample_req_i = 1'b0;
        sample_pc_i = '0; sample_regs_i = '0; rec_ready_i = 1'b0;
        m_busy_left = 0; m_occ = 0; m_drop = 0; m_regs = '0;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[1] = 64'h11; rf[2] = 64'h22; rf[3] = 64'h33; rf[4] = 64'h44;

        step(1'b0, 1'b0, 64'd0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'd0, '0, 1'b0, 1'b1);

        // Single sample, then drain
        req1(64'h8000_0000, mk_regs(1, 2, 3, 4), 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Back-to-back requests: second one is dropped
        req1(64'h100, mk_regs(5, 6, 7, 8), 1'b0);
        req1(64'h104, mk_regs(9, 10, 11, 12), 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Fill the FIFO and overflow it once
        for (int i = 0; i < 5; i++) begin
            req1(64'h2000 + 64'(i), mk_regs(i, i + 1, i + 2, i + 3), 1'b0);
            idle(2, 1'b0);
        end
        // Full FIFO with a pop exactly in the capture cycle
        req1(64'h3000, mk_regs(20, 21, 22, 23), 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(6, 1'b1);

        // Reset while the address is on the port
        req1(64'h4000, mk_regs(13, 14, 15, 16), 1'b0);
        step(1'b1, 1'b0, 64'd0, '0, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Disabled request is ignored, then repeated busy drops saturate
        step(1'b0, 1'b1, 64'h5000, mk_regs(1, 1, 1, 1), 1'b1, 1'b0);
        idle(2, 1'b1);
        for (int i = 0; i < 8; i++) req1(64'h6000 + 64'(i), mk_regs(i, 2 * i, 3 * i, 31 - i), 1'b1);
        idle(4, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(7) != 0), ($urandom_range(2) == 0),
                 {$urandom, $urandom}, 20'($urandom), $urandom_range(1) == 1'b1,
                 ($urandom_range(149) == 0));
        end
        idle(12, 1'b1);
        chk("leftover_records", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ebs_regfile_sampler.md
Name: ebs_regfile_sampler

Overview:
- Requester side of the EBS register-file snapshot port on the issue stage (ebs_regfile_addr / ebs_regfile_data).
- On a sample event, drives four architectural register indices and captures the four XLEN values one cycle later.
- Tags the captured values with the event PC and buffers the record in a small FIFO.
- Downstream sampling logic drains the FIFO through a valid/ready stream.

Parameters:
- XLEN, 64, width of each sampled register value.
- VLEN, 64, width of the event PC tag.
- FIFO_DEPTH, 4, number of buffered sample records (power of 2, ≥2).
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  sampler enable; when low, sample requests are ignored and not counted.
- sample_req_i  in  1  single-cycle sample event.
- sample_pc_i  in  VLEN  PC tag, captured with sample_req_i.
- sample_regs_i  in  4x5  register indices to snapshot, captured with sample_req_i.
- ebs_regfile_addr_o  out  4x5  indices presented to the issue stage.
- ebs_regfile_data_i  in  4xXLEN  register values, valid one cycle after the address.
- rec_valid_o  out  1  FIFO head record valid.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_pc_o  out  VLEN  head record PC.
- rec_data_o  out  4xXLEN  head record register values, index k corresponds to sample_regs_i[k].
- busy_o  out  1  high while a capture is in flight.
- drop_cnt_o  out  DROP_CNT_W  saturating count of lost samples.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - FSM returns to IDLE; FIFO is emptied; drop_cnt_o is cleared to 0.
  - ebs_regfile_addr_o=0, rec_valid_o=0, busy_o=0.
  - rec_pc_o and rec_data_o read 0.
  - Reset mid-capture discards the in-flight sample and does not count it as a drop.
- FSM states: IDLE, ADDR, CAPT.
  - IDLE: a request (en_i & sample_req_i) latches sample_pc_i and sample_regs_i, then moves to ADDR.
  - ADDR: ebs_regfile_addr_o = latched indices; busy_o=1. Moves to CAPT unconditionally.
  - CAPT: ebs_regfile_addr_o is held; busy_o=1; ebs_regfile_data_i is written into the FIFO together with the latched PC. Moves to IDLE.
  - ebs_regfile_addr_o returns to 0 in IDLE.
- Latency: request at cycle t → addresses driven at t+1 → data captured at end of t+2 → rec_valid_o=1 at t+3 if the FIFO was empty. The earliest next request accepted is at t+3.
- A request while in ADDR or CAPT with en_i=1 is dropped: drop_cnt_o increments by 1.
- FIFO:
  - rec_* outputs show the head entry; pop on rec_valid_o & rec_ready_i.
  - Push in CAPT succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle; occupancy is then unchanged.
  - Otherwise the record is discarded and drop_cnt_o increments.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on an empty FIFO: the pop is invalid (rec_valid_o=0), so the push proceeds and occupancy becomes 1.
- Drop counter:
  - Saturates at all-ones and never wraps.
  - Two drop causes in the same cycle (busy request plus full-FIFO discard) increment it by 2, saturating.
- No special handling for index 0; the value returned by the issue stage is recorded as is.
- en_i deassertion does not abort a capture already in ADDR or CAPT.

Test Plan:
- Single sample:
  - Stimulus: reset; regs={1,2,3,4}, pc=0x8000_0000 at t; regfile returns 0x11, 0x22, 0x33, 0x44 at t+2.
  - Required: addr_o={1,2,3,4} at t+1 and t+2; rec_valid_o=1 at t+3 with rec_pc_o=0x8000_0000 and rec_data_o={0x11,0x22,0x33,0x44}; drop_cnt_o=0.
- Busy drop:
  - Stimulus: requests at t and t+1.
  - Required: only one record is produced; drop_cnt_o=1 at t+2.
- FIFO full:
  - Stimulus: rec_ready_i=0; 5 requests spaced 3 cycles apart with FIFO_DEPTH=4.
  - Required: 4 records are held; drop_cnt_o=1. After draining, the records come out in request order.
- Full with concurrent pop:
  - Stimulus: FIFO full; rec_ready_i=1 exactly during the CAPT cycle.
  - Required: the head pops, the new record is pushed, occupancy stays 4, drop_cnt_o is unchanged.
- Reset mid-capture:
  - Stimulus: assert rst_i during ADDR.
  - Required: next cycle busy_o=0, ebs_regfile_addr_o=0, rec_valid_o=0, drop_cnt_o=0; no record appears.
- Enable and saturation:
  - Stimulus: request with en_i=0; then, with DROP_CNT_W=2, force 5 busy drops.
  - Required: the en_i=0 request produces no FSM transition and no count; drop_cnt_o stays at 3.
